cfg_change_streamer: RTL and testbench

//  Consumer of the flat cfg_data bus driven by the AXI config register bank.

---
 rtl/cfg_change_streamer.sv | 155 +++++++++++++++
 tb/tb_cfg_change_streamer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_change_streamer.sv
// Shadows a flat configuration bus, scans it one word per cycle and emits every
// word that differs from its shadow copy as a single AXI-Stream beat.
module cfg_change_streamer #(
  parameter  int CFG_DATA_WIDTH = 1024,
  parameter  int AXI_DATA_WIDTH = 32,
  localparam int NWORDS         = CFG_DATA_WIDTH / AXI_DATA_WIDTH,
  localparam int IDX_W          = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [CFG_DATA_WIDTH-1:0] cfg_data,
  input  logic                      enable,
  input  logic                      resync,
  output logic [AXI_DATA_WIDTH-1:0] m_axis_tdata,
  output logic [IDX_W-1:0]          m_axis_tuser,
  output logic                      m_axis_tlast,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      pass_done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_SEND = 2'd2
  } state_e;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

  state_e                                 state_q, state_d;
  logic [NWORDS-1:0][AXI_DATA_WIDTH-1:0]  shadow_q, shadow_d;
  logic [IDX_W-1:0]                       ptr_q, ptr_d;
  logic                                   pend_q, pend_d;
  logic [AXI_DATA_WIDTH-1:0]              tdata_q, tdata_d;
  logic [IDX_W-1:0]                       tuser_q, tuser_d;
  logic                                   tlast_q, tlast_d;
  logic                                   tvalid_q, tvalid_d;
  logic                                   pass_done_q, pass_done_d;

  logic [NWORDS-1:0][AXI_DATA_WIDTH-1:0]  cfg_words_s;
  logic [AXI_DATA_WIDTH-1:0]              cur_word_s;
  logic                                   ptr_wrap_s;
  logic                                   do_resync_s;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    if (idx == LAST_IDX) begin
      return '0;
    end else begin
      return idx + IDX_W'(1);
    end
  endfunction

  assign cfg_words_s = cfg_data;
  assign cur_word_s  = cfg_words_s[ptr_q];
  assign ptr_wrap_s  = (ptr_q == LAST_IDX);
  // A resync requested during SEND is held in pend_q and honoured once the beat is gone.
  assign do_resync_s = resync | pend_q;

  // Next-state, shadow update and output-register logic of the scan FSM.
  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    ptr_d       = ptr_q;
    pend_d      = pend_q;
    tdata_d     = tdata_q;
    tuser_d     = tuser_q;
    tlast_d     = tlast_q;
    tvalid_d    = tvalid_q;
    pass_done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (do_resync_s) begin
          shadow_d = cfg_words_s;
          ptr_d    = '0;
          pend_d   = 1'b0;
        end else begin
          shadow_d = shadow_q;
        end
        state_d = enable ? ST_SCAN : ST_IDLE;
      end

      ST_SCAN: begin
        if (do_resync_s) begin
          shadow_d = cfg_words_s;
          ptr_d    = '0;
          pend_d   = 1'b0;
          state_d  = enable ? ST_SCAN : ST_IDLE;
        end else if (cur_word_s != shadow_q[ptr_q]) begin
          shadow_d[ptr_q] = cur_word_s;
          tdata_d         = cur_word_s;
          tuser_d         = ptr_q;
          tlast_d         = ptr_wrap_s;
          tvalid_d        = 1'b1;
          state_d         = ST_SEND;
        end else begin
          ptr_d       = next_idx(ptr_q);
          pass_done_d = ptr_wrap_s;
          state_d     = enable ? ST_SCAN : ST_IDLE;
        end
      end

      ST_SEND: begin
        pend_d = pend_q | resync;
        // The pointer only moves past a changed word once its beat is accepted.
        if (m_axis_tready) begin
          tvalid_d    = 1'b0;
          ptr_d       = next_idx(ptr_q);
          pass_done_d = ptr_wrap_s;
          state_d     = enable ? ST_SCAN : ST_IDLE;
        end else begin
          tvalid_d = 1'b1;
          state_d  = ST_SEND;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        tvalid_d = 1'b0;
      end
    endcase
  end

  // State, shadow copy and registered stream outputs.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      shadow_q    <= '0;
      ptr_q       <= '0;
      pend_q      <= 1'b0;
      tdata_q     <= '0;
      tuser_q     <= '0;
      tlast_q     <= 1'b0;
      tvalid_q    <= 1'b0;
      pass_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      ptr_q       <= ptr_d;
      pend_q      <= pend_d;
      tdata_q     <= tdata_d;
      tuser_q     <= tuser_d;
      tlast_q     <= tlast_d;
      tvalid_q    <= tvalid_d;
      pass_done_q <= pass_done_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tuser  = tuser_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tvalid = tvalid_q;
  assign pass_done     = pass_done_q;

endmodule

// File: tb/tb_cfg_change_streamer.sv
// Bench for cfg_change_streamer: directed table, hand-written corner sequences
// and a randomized run, all checked against a cycle-level reference model.
module tb_cfg_change_streamer;

  localparam int NW = 32;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [1023:0] cfg_data = '0;
  logic          enable = 1'b0;
  logic          resync = 1'b0;
  logic          m_axis_tready = 1'b0;
  logic [31:0]   m_axis_tdata;
  logic [4:0]    m_axis_tuser;
  logic          m_axis_tlast;
  logic          m_axis_tvalid;
  logic          pass_done;

  int vectors = 0;
  int miscompares = 0;

  always #5 aclk = ~aclk;

  cfg_change_streamer dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .cfg_data      (cfg_data),
    .enable        (enable),
    .resync        (resync),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .pass_done     (pass_done)
  );

  // Reference model state: shadow array, scan position and expected outputs.
  logic [31:0] m_shadow [NW];
  int          m_ptr;
  bit          m_busy, m_run, m_pend;
  logic [31:0] e_data;
  int          e_user;
  bit          e_last, e_valid, e_pd;

  typedef struct { int user; logic [31:0] data; bit last; } beat_t;
  beat_t beats_q[$];

  typedef struct { int idx; logic [31:0] val; int exp_user; logic [31:0] exp_data; bit exp_last; } vec_t;
  vec_t tbl[7];

  function automatic logic [31:0] word_of(int k);
    return cfg_data[k*32 +: 32];
  endfunction

  task automatic set_word(int k, logic [31:0] v);
    cfg_data[k*32 +: 32] = v;
  endtask

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NW; i++) m_shadow[i] = '0;
    m_ptr = 0; m_busy = 0; m_run = 0; m_pend = 0;
    e_data = '0; e_user = 0; e_last = 0; e_valid = 0; e_pd = 0;
  endtask

  task automatic model_advance();
    if (m_ptr == NW - 1) begin
      m_ptr = 0;
      e_pd  = 1;
    end else begin
      m_ptr = m_ptr + 1;
    end
  endtask

  task automatic model_resync();
    for (int i = 0; i < NW; i++) m_shadow[i] = word_of(i);
    m_ptr  = 0;
    m_pend = 0;
  endtask

  // Evaluated with the inputs that will be sampled at the coming rising edge.
  task automatic model_step();
    logic [31:0] w;
    if (!aresetn) begin
      model_reset();
    end else begin
      e_pd = 0;
      if (m_busy) begin
        if (resync) m_pend = 1;
        if (m_axis_tready) begin
          m_busy = 0; e_valid = 0;
          model_advance();
          m_run = enable;
        end
      end else if (!m_run) begin
        if (resync || m_pend) model_resync();
        m_run = enable;
      end else if (resync || m_pend) begin
        model_resync();
        m_run = enable;
      end else begin
        w = word_of(m_ptr);
        if (w != m_shadow[m_ptr]) begin
          m_shadow[m_ptr] = w;
          e_data = w; e_user = m_ptr; e_last = (m_ptr == NW - 1);
          e_valid = 1; m_busy = 1;
        end else begin
          model_advance();
          m_run = enable;
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [39:0] act, exp;
    act = {m_axis_tvalid, pass_done, m_axis_tlast, m_axis_tuser, m_axis_tdata};
    exp = {e_valid, e_pd, e_last, 5'(e_user), e_data};
    if (!e_valid) begin
      act[37:0] = '0;
      exp[37:0] = '0;
    end
    check("cycle_outputs", act, exp);
  endtask

  task automatic tick();
    if (aresetn && m_axis_tvalid && m_axis_tready)
      beats_q.push_back('{int'(m_axis_tuser), m_axis_tdata, m_axis_tlast});
    model_step();
    @(posedge aclk); #1;
    check_outputs();
  endtask

  task automatic wait_valid(string name, int budget);
    int n = 0;
    while (!m_axis_tvalid && n < budget) begin
      tick();
      n++;
    end
    check(name, m_axis_tvalid, 1);
  endtask

  task automatic check_one_beat(string name, int user, logic [31:0] data, bit last);
    check({name, "_count"}, beats_q.size(), 1);
    if (beats_q.size() > 0)
      check(name, {5'(beats_q[0].user), beats_q[0].data, beats_q[0].last}, {5'(user), data, last});
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    #1;
    check("reset_outputs", {m_axis_tvalid, pass_done, m_axis_tlast, m_axis_tuser, m_axis_tdata}, '0);
    model_reset();
    repeat (3) tick();
    aresetn = 1'b1;
  endtask

  // Beat is held with tready low while resync arrives, either before or on the handshake cycle.
  task automatic resync_during_send(int k, logic [31:0] v, int k2, logic [31:0] v2, bit on_handshake);
    m_axis_tready = 1'b0;
    beats_q.delete();
    set_word(k, v);
    wait_valid("rs_send_valid", 80);
    repeat (2) tick();
    if (on_handshake) m_axis_tready = 1'b1;
    resync = 1'b1;
    set_word(k2, v2);
    tick();
    resync = 1'b0;
    repeat (2) tick();
    m_axis_tready = 1'b1;
    repeat (72) tick();
    check_one_beat("rs_send_beat", k, v, 1'b0);
  endtask

  initial begin
    int pd_cnt, pd_first;
    int exp_idx[$];

    tbl[0] = '{3,  32'hCAFE_F00D, 3,  32'hCAFE_F00D, 1'b0};
    tbl[1] = '{24, 32'h0000_0000, 24, 32'h0000_0000, 1'b0};
    tbl[2] = '{31, 32'h1234_5678, 31, 32'h1234_5678, 1'b1};
    tbl[3] = '{0,  32'h0000_0001, 0,  32'h0000_0001, 1'b0};
    tbl[4] = '{16, 32'hFFFF_FFFF, 16, 32'hFFFF_FFFF, 1'b0};
    tbl[5] = '{30, 32'h8000_0000, 30, 32'h8000_0000, 1'b0};
    tbl[6] = '{1,  32'h3344_5567, 1,  32'h3344_5567, 1'b0};

    // T1: idle bus, pass_done every 32 scan cycles.
    do_reset();
    enable = 1'b1;
    m_axis_tready = 1'b1;
    pd_cnt = 0; pd_first = 0;
    beats_q.delete();
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (pass_done) begin
        pd_cnt++;
        if (pd_first == 0) pd_first = i;
      end
    end
    check("t1_beats", beats_q.size(), 0);
    check("t1_pd_count", pd_cnt, 3);
    check("t1_pd_first", pd_first, 33);

    // T2: two words change together; pointer restarted at 0 by resync.
    resync = 1'b1;
    tick();
    resync = 1'b0;
    beats_q.delete();
    set_word(1, 32'h3344_5566);
    set_word(24, 32'h1122_3344);
    repeat (72) tick();
    check("t2_count", beats_q.size(), 2);
    if (beats_q.size() >= 2) begin
      check("t2_beat0", {5'(beats_q[0].user), beats_q[0].data, beats_q[0].last}, {5'd1, 32'h3344_5566, 1'b0});
      check("t2_beat1", {5'(beats_q[1].user), beats_q[1].data, beats_q[1].last}, {5'd24, 32'h1122_3344, 1'b0});
    end

    // Single-word changes, one beat each.
    for (int i = 0; i < 7; i++) begin
      beats_q.delete();
      set_word(tbl[i].idx, tbl[i].val);
      repeat (72) tick();
      check_one_beat("tbl_beat", tbl[i].exp_user, tbl[i].exp_data, tbl[i].exp_last);
    end

    // T3: stalled sink holds the beat for word 31.
    m_axis_tready = 1'b0;
    beats_q.delete();
    set_word(31, 32'hDEAD_BEEF);
    wait_valid("t3_valid", 80);
    repeat (20) tick();
    check("t3_hold", {m_axis_tvalid, m_axis_tuser, m_axis_tdata, m_axis_tlast}, {1'b1, 5'd31, 32'hDEAD_BEEF, 1'b1});
    m_axis_tready = 1'b1;
    repeat (40) tick();
    check_one_beat("t3_beat", 31, 32'hDEAD_BEEF, 1'b1);

    // T4: three writes to word 5 before the pointer gets there.
    resync = 1'b1;
    tick();
    resync = 1'b0;
    beats_q.delete();
    set_word(5, 32'hA); tick();
    set_word(5, 32'hB); tick();
    set_word(5, 32'hC);
    repeat (72) tick();
    check_one_beat("t4_beat", 5, 32'hC, 1'b0);

    // T5: resync absorbs changes; a later change is still reported.
    beats_q.delete();
    set_word(2, 32'h2222_0000);
    set_word(3, 32'h3333_0000);
    resync = 1'b1;
    tick();
    resync = 1'b0;
    repeat (72) tick();
    check("t5_no_beats", beats_q.size(), 0);
    set_word(2, 32'h2222_2222);
    repeat (72) tick();
    check_one_beat("t5_beat", 2, 32'h2222_2222, 1'b0);

    resync_during_send(10, 32'h1010_1010, 11, 32'h1111_1111, 1'b0);
    resync_during_send(12, 32'h1212_1212, 13, 32'h1313_1313, 1'b1);

    // Randomized traffic against the model.
    for (int i = 0; i < 2500; i++) begin
      m_axis_tready = ($urandom_range(0, 3) != 0);
      enable        = ($urandom_range(0, 15) != 0);
      resync        = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 2))
          0: set_word($urandom_range(0, NW - 1), 32'h0);
          1: set_word($urandom_range(0, NW - 1), 32'h5);
          default: set_word($urandom_range(0, NW - 1), $urandom);
        endcase
      end
      tick();
    end

    // T6: reset mid-SEND drops the beat; afterwards every nonzero word is re-emitted in order.
    resync = 1'b0;
    enable = 1'b1;
    m_axis_tready = 1'b0;
    set_word(7, ~word_of(7));
    wait_valid("t6_valid", 80);
    tick();
    aresetn = 1'b0;
    #1;
    check("t6_tvalid_drop", m_axis_tvalid, 0);
    do_reset();
    m_axis_tready = 1'b1;
    beats_q.delete();
    for (int k = 0; k < NW; k++) if (word_of(k) != 32'h0) exp_idx.push_back(k);
    repeat (120) tick();
    check("t6_count", beats_q.size(), exp_idx.size());
    for (int j = 0; j < exp_idx.size() && j < beats_q.size(); j++)
      check("t6_beat", {5'(beats_q[j].user), beats_q[j].data, beats_q[j].last},
            {5'(exp_idx[j]), word_of(exp_idx[j]), exp_idx[j] == NW - 1});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
